// File: rtl/balance_spd_shaper_if.sv
// rtl/balance_spd_shaper_if.sv - sample/command and speed-output bundle for balance_spd_shaper
//
// Purpose: groups the per-sample inputs and the speed/status outputs of the
// balance speed shaper so that the driver and the shaper share one port.
// Signals:
//   vld        sample strobe, advances soft-start
//   pwr_up     power enable, low forces zero output
//   rider_off  no rider, zeroes targets and soft-start
//   PID_cntrl  signed PID command (SPD_W)
//   steer_pot  unsigned steering pot (12)
//   en_steer   steering enable
//   lft_spd    signed left wheel speed (SPD_W)
//   rght_spd   signed right wheel speed (SPD_W)
//   too_fast   debounced overspeed flag
//   ss_tmr     soft-start timer (SS_W)
// Modports: master drives the samples, slave (the shaper) drives the speeds.

interface balance_spd_shaper_if #(
    parameter int SPD_W = 12,
    parameter int SS_W  = 8
);
    logic                    vld;
    logic                    pwr_up;
    logic                    rider_off;
    logic signed [SPD_W-1:0] PID_cntrl;
    logic [11:0]             steer_pot;
    logic                    en_steer;
    logic signed [SPD_W-1:0] lft_spd;
    logic signed [SPD_W-1:0] rght_spd;
    logic                    too_fast;
    logic [SS_W-1:0]         ss_tmr;

    modport master (
        output vld, pwr_up, rider_off, PID_cntrl, steer_pot, en_steer,
        input  lft_spd, rght_spd, too_fast, ss_tmr
    );

    modport slave (
        input  vld, pwr_up, rider_off, PID_cntrl, steer_pot, en_steer,
        output lft_spd, rght_spd, too_fast, ss_tmr
    );
endinterface

// File: rtl/balance_spd_shaper.sv
// rtl/balance_spd_shaper.sv - soft-start, steering blend, saturation and overspeed output stage
//
// Purpose: scales the PID command by a soft-start ramp, adds/subtracts the
// steering term, saturates each wheel speed, debounces an overspeed flag and
// delivers everything through a PIPE_DEPTH-stage register pipeline.
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    balance_spd_shaper_if.slave (samples in, speeds/status out)
// Optional feature: define BAL_SLEW_LIMIT_EN to rate-limit the final output
// stage by SLEW_STEP per clock; undefined, the final stage loads the target.

module balance_spd_shaper #(
    parameter int SPD_W        = 12,
    parameter int PIPE_DEPTH   = 2,
    parameter int SS_W         = 8,
    parameter int FAST_SIM     = 1,
    parameter int TOO_FAST_LIM = 1536,
    parameter int TOO_FAST_CNT = 4,
    parameter int SLEW_STEP    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    balance_spd_shaper_if.slave  bus
);
    localparam int              LAST    = PIPE_DEPTH - 1;
    localparam int              PW      = SPD_W + SS_W + 1;
    localparam logic [SS_W-1:0] SS_MAX  = '1;
    localparam logic [SPD_W:0]  LIM     = (SPD_W+1)'(TOO_FAST_LIM);
    localparam logic [3:0]      CNT_MAX = 4'(TOO_FAST_CNT);

    // ---------------- soft-start timer ----------------
    logic [SS_W-1:0] ss_q;
    logic [3:0]      presc_q;
    logic            ss_step;

    // With FAST_SIM=0 only the vld that wraps the prescaler advances the ramp.
    assign ss_step = bus.vld && ((FAST_SIM != 0) || (presc_q == 4'hF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q    <= '0;
            presc_q <= '0;
        end else if (!bus.pwr_up || bus.rider_off) begin
            ss_q    <= '0;
            presc_q <= '0;
        end else begin
            if (bus.vld && (FAST_SIM == 0))
                presc_q <= presc_q + 4'd1;
            if (ss_step && (ss_q != SS_MAX))
                ss_q <= ss_q + SS_W'(1);
        end
    end

    // ---------------- soft-start scaling ----------------
    logic signed [PW-1:0]    pid_ext, ss_ext, prod, prod_sh;
    logic signed [SPD_W-1:0] pid_ss;

    always_comb begin
        pid_ext = PW'(bus.PID_cntrl);
        ss_ext  = PW'({1'b0, ss_q});
        prod    = pid_ext * ss_ext;
        prod_sh = prod >>> SS_W;
        pid_ss  = SPD_W'(prod_sh);
        // A full ramp passes the command through untouched instead of x255/256.
        if (ss_q == SS_MAX)
            pid_ss = bus.PID_cntrl;
        if (bus.rider_off)
            pid_ss = '0;
    end

    // ---------------- steering ----------------
    logic [11:0]             pot_clip;
    logic signed [11:0]      s12;
    logic signed [13:0]      s_ext, s3, steer14;
    logic signed [SPD_W-1:0] steer;

    always_comb begin
        if (bus.steer_pot < 12'h200)
            pot_clip = 12'h200;
        else if (bus.steer_pot > 12'hE00)
            pot_clip = 12'hE00;
        else
            pot_clip = bus.steer_pot;
        s12     = pot_clip - 12'h7FF;
        s_ext   = 14'(s12);
        s3      = s_ext + (s_ext <<< 1);
        steer14 = s3 >>> 4;
        steer   = SPD_W'(steer14);
        if (!bus.en_steer || bus.rider_off)
            steer = '0;
    end

    // ---------------- sums, saturation, overspeed ----------------
    function automatic logic signed [SPD_W-1:0] sat(input logic signed [SPD_W:0] v);
        if (v[SPD_W] != v[SPD_W-1])
            return v[SPD_W] ? {1'b1, {(SPD_W-1){1'b0}}} : {1'b0, {(SPD_W-1){1'b1}}};
        return v[SPD_W-1:0];
    endfunction

    function automatic logic [SPD_W:0] mag(input logic signed [SPD_W:0] v);
        return v[SPD_W] ? -v : v;
    endfunction

    logic signed [SPD_W:0] lft_raw, rght_raw;
    logic                  over;
    logic [3:0]            cnt_q, cnt_next;
    logic                  tf_new;

    always_comb begin
        lft_raw  = (SPD_W+1)'(pid_ss) + (SPD_W+1)'(steer);
        rght_raw = (SPD_W+1)'(pid_ss) - (SPD_W+1)'(steer);
        over     = (mag(lft_raw) > LIM) || (mag(rght_raw) > LIM);
        if (!over)
            cnt_next = 4'd0;
        else if (cnt_q >= CNT_MAX)
            cnt_next = CNT_MAX;
        else
            cnt_next = cnt_q + 4'd1;
        // Flag is decided from the post-update count so it belongs to this sample.
        tf_new = (cnt_next >= CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (!bus.pwr_up)
            cnt_q <= '0;
        else
            cnt_q <= cnt_next;
    end

    // ---------------- pipeline ----------------
    logic signed [SPD_W-1:0] lft_stg [PIPE_DEPTH];
    logic signed [SPD_W-1:0] rght_stg[PIPE_DEPTH];
    logic                    tf_stg  [PIPE_DEPTH];
    logic signed [SPD_W-1:0] lft_in  [PIPE_DEPTH];
    logic signed [SPD_W-1:0] rght_in [PIPE_DEPTH];
    logic                    tf_in   [PIPE_DEPTH];
    logic signed [SPD_W-1:0] lft_fin, rght_fin;

    always_comb begin
        lft_in[0]  = sat(lft_raw);
        rght_in[0] = sat(rght_raw);
        tf_in[0]   = tf_new;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            lft_in[i]  = lft_stg[i-1];
            rght_in[i] = rght_stg[i-1];
            tf_in[i]   = tf_stg[i-1];
        end
    end

`ifdef BAL_SLEW_LIMIT_EN
    localparam logic signed [SPD_W:0] STEP = (SPD_W+1)'(SLEW_STEP);

    // Moves cur toward target by at most STEP; the result always lies between
    // cur and target, so it cannot leave the SPD_W range.
    function automatic logic signed [SPD_W-1:0] slew(
        input logic signed [SPD_W-1:0] target,
        input logic signed [SPD_W-1:0] cur
    );
        logic signed [SPD_W:0] diff;
        diff = (SPD_W+1)'(target) - (SPD_W+1)'(cur);
        if (diff > STEP)
            diff = STEP;
        else if (diff < -STEP)
            diff = -STEP;
        return SPD_W'((SPD_W+1)'(cur) + diff);
    endfunction

    always_comb begin
        lft_fin  = slew(lft_in[LAST], lft_stg[LAST]);
        rght_fin = slew(rght_in[LAST], rght_stg[LAST]);
    end
`else
    always_comb begin
        lft_fin  = lft_in[LAST];
        rght_fin = rght_in[LAST];
    end
`endif

    // Power-down clears every stage at once, so the output drops to zero on
    // the next edge regardless of the slew limiter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                lft_stg[i]  <= '0;
                rght_stg[i] <= '0;
                tf_stg[i]   <= 1'b0;
            end
        end else if (!bus.pwr_up) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                lft_stg[i]  <= '0;
                rght_stg[i] <= '0;
                tf_stg[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < LAST; i++) begin
                lft_stg[i]  <= lft_in[i];
                rght_stg[i] <= rght_in[i];
            end
            lft_stg[LAST]  <= lft_fin;
            rght_stg[LAST] <= rght_fin;
            for (int i = 0; i < PIPE_DEPTH; i++)
                tf_stg[i] <= tf_in[i];
        end
    end

    assign bus.lft_spd  = lft_stg[LAST];
    assign bus.rght_spd = rght_stg[LAST];
    assign bus.too_fast = tf_stg[LAST];
    assign bus.ss_tmr   = ss_q;

endmodule

// File: tb/tb_balance_spd_shaper.sv
// tb/tb_balance_spd_shaper.sv - directed self-checking bench for balance_spd_shaper

module tb_balance_spd_shaper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    balance_spd_shaper_if #(.SPD_W(12), .SS_W(8)) bus();

    balance_spd_shaper #(
        .SPD_W(12), .PIPE_DEPTH(2), .SS_W(8), .FAST_SIM(1),
        .TOO_FAST_LIM(1536), .TOO_FAST_CNT(4), .SLEW_STEP(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.vld = 1'b1; bus.pwr_up = 1'b1; bus.rider_off = 1'b0; bus.en_steer = 1'b1;
        bus.PID_cntrl = 12'($urandom); bus.steer_pot = 12'($urandom);
        rst_n = 1'b0;
        step(3);
        checks++; if (bus.lft_spd !== 12'sd0) $display("FAIL rst_lft got=%0d want=0", bus.lft_spd); else passes++;
        checks++; if (bus.rght_spd !== 12'sd0) $display("FAIL rst_rght got=%0d want=0", bus.rght_spd); else passes++;
        checks++; if (bus.too_fast !== 1'b0) $display("FAIL rst_too_fast got=%0b want=0", bus.too_fast); else passes++;
        checks++; if (bus.ss_tmr !== 8'd0) $display("FAIL rst_ss got=%0d want=0", bus.ss_tmr); else passes++;
        bus.pwr_up = 1'b0;
        rst_n = 1'b1;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd0) $display("FAIL rel_lft got=%0d want=0", bus.lft_spd); else passes++;
        checks++; if (bus.ss_tmr !== 8'd0) $display("FAIL rel_ss got=%0d want=0", bus.ss_tmr); else passes++;
    endtask

    task automatic test_soft_start;
        bus.pwr_up = 1'b1; bus.rider_off = 1'b0; bus.vld = 1'b1;
        bus.PID_cntrl = 12'sd1024; bus.en_steer = 1'b0; bus.steer_pot = 12'h000;
        step(128);
        checks++; if (bus.ss_tmr !== 8'd128) $display("FAIL ss_128 got=%0d want=128", bus.ss_tmr); else passes++;
        bus.vld = 1'b0;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd508) $display("FAIL ss127_lft got=%0d want=508", bus.lft_spd); else passes++;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd512) $display("FAIL ss128_lft got=%0d want=512", bus.lft_spd); else passes++;
        checks++; if (bus.rght_spd !== 12'sd512) $display("FAIL ss128_rght got=%0d want=512", bus.rght_spd); else passes++;
        bus.vld = 1'b1;
        step(200);
        checks++; if (bus.ss_tmr !== 8'd255) $display("FAIL ss_sat got=%0d want=255", bus.ss_tmr); else passes++;
        checks++; if (bus.lft_spd !== 12'sd1024) $display("FAIL ss_full_lft got=%0d want=1024", bus.lft_spd); else passes++;
        bus.PID_cntrl = 12'sd512;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd1024) $display("FAIL lat_hold got=%0d want=1024", bus.lft_spd); else passes++;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd512) $display("FAIL lat_new got=%0d want=512", bus.lft_spd); else passes++;
    endtask

    task automatic test_steering;
        bus.PID_cntrl = 12'sd0; bus.en_steer = 1'b1; bus.steer_pot = 12'hFFF;
        step(2);
        checks++; if (bus.lft_spd !== 12'sd288) $display("FAIL steer_hi_lft got=%0d want=288", bus.lft_spd); else passes++;
        checks++; if (bus.rght_spd !== -12'sd288) $display("FAIL steer_hi_rght got=%0d want=-288", bus.rght_spd); else passes++;
        bus.steer_pot = 12'h000;
        step(2);
        checks++; if (bus.lft_spd !== -12'sd288) $display("FAIL steer_lo_lft got=%0d want=-288", bus.lft_spd); else passes++;
        checks++; if (bus.rght_spd !== 12'sd288) $display("FAIL steer_lo_rght got=%0d want=288", bus.rght_spd); else passes++;
        bus.PID_cntrl = 12'sd100; bus.steer_pot = 12'h8FF;
        step(2);
        checks++; if (bus.lft_spd !== 12'sd148) $display("FAIL steer_mid_lft got=%0d want=148", bus.lft_spd); else passes++;
        checks++; if (bus.rght_spd !== 12'sd52) $display("FAIL steer_mid_rght got=%0d want=52", bus.rght_spd); else passes++;
        bus.PID_cntrl = 12'sd0; bus.steer_pot = 12'hFFF; bus.en_steer = 1'b0;
        step(2);
        checks++; if (bus.lft_spd !== 12'sd0) $display("FAIL steer_off_lft got=%0d want=0", bus.lft_spd); else passes++;
        checks++; if (bus.rght_spd !== 12'sd0) $display("FAIL steer_off_rght got=%0d want=0", bus.rght_spd); else passes++;
    endtask

    task automatic test_overspeed;
        bus.PID_cntrl = 12'sd2000; bus.steer_pot = 12'hE00; bus.en_steer = 1'b1;
        step(2);
        checks++; if (bus.lft_spd !== 12'sd2047) $display("FAIL ovr_lft_sat got=%0d want=2047", bus.lft_spd); else passes++;
        checks++; if (bus.rght_spd !== 12'sd1712) $display("FAIL ovr_rght got=%0d want=1712", bus.rght_spd); else passes++;
        checks++; if (bus.too_fast !== 1'b0) $display("FAIL ovr_tf1 got=%0b want=0", bus.too_fast); else passes++;
        step(2);
        checks++; if (bus.too_fast !== 1'b0) $display("FAIL ovr_tf3 got=%0b want=0", bus.too_fast); else passes++;
        step(1);
        checks++; if (bus.too_fast !== 1'b1) $display("FAIL ovr_tf4 got=%0b want=1", bus.too_fast); else passes++;
        bus.PID_cntrl = 12'sd0;
        step(1);
        checks++; if (bus.too_fast !== 1'b1) $display("FAIL ovr_tf5 got=%0b want=1", bus.too_fast); else passes++;
        bus.PID_cntrl = 12'sd2000;
        step(1);
        checks++; if (bus.too_fast !== 1'b0) $display("FAIL ovr_drop got=%0b want=0", bus.too_fast); else passes++;
        checks++; if (bus.lft_spd !== 12'sd288) $display("FAIL ovr_drop_lft got=%0d want=288", bus.lft_spd); else passes++;
        step(3);
        checks++; if (bus.too_fast !== 1'b0) $display("FAIL ovr_restart3 got=%0b want=0", bus.too_fast); else passes++;
        step(1);
        checks++; if (bus.too_fast !== 1'b1) $display("FAIL ovr_restart4 got=%0b want=1", bus.too_fast); else passes++;
        step(5);
        checks++; if (bus.too_fast !== 1'b1) $display("FAIL ovr_hold got=%0b want=1", bus.too_fast); else passes++;
    endtask

    task automatic test_power_down;
        bus.pwr_up = 1'b0;
        step(1);
        checks++; if (bus.too_fast !== 1'b0) $display("FAIL pd_tf got=%0b want=0", bus.too_fast); else passes++;
        checks++; if (bus.lft_spd !== 12'sd0) $display("FAIL pd_lft got=%0d want=0", bus.lft_spd); else passes++;
        bus.pwr_up = 1'b1; bus.vld = 1'b1; bus.PID_cntrl = 12'sd1024; bus.en_steer = 1'b0; bus.rider_off = 1'b0;
        step(100);
        checks++; if (bus.ss_tmr !== 8'd100) $display("FAIL ramp_ss got=%0d want=100", bus.ss_tmr); else passes++;
        checks++; if (bus.lft_spd !== 12'sd392) $display("FAIL ramp_lft got=%0d want=392", bus.lft_spd); else passes++;
        bus.pwr_up = 1'b0;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd0) $display("FAIL drop_lft got=%0d want=0", bus.lft_spd); else passes++;
        checks++; if (bus.rght_spd !== 12'sd0) $display("FAIL drop_rght got=%0d want=0", bus.rght_spd); else passes++;
        checks++; if (bus.ss_tmr !== 8'd0) $display("FAIL drop_ss got=%0d want=0", bus.ss_tmr); else passes++;
        bus.pwr_up = 1'b1;
        step(50);
        checks++; if (bus.lft_spd !== 12'sd192) $display("FAIL ramp50_lft got=%0d want=192", bus.lft_spd); else passes++;
        bus.rider_off = 1'b1; bus.en_steer = 1'b1; bus.steer_pot = 12'hFFF;
        step(1);
        checks++; if (bus.ss_tmr !== 8'd0) $display("FAIL roff_ss got=%0d want=0", bus.ss_tmr); else passes++;
        checks++; if (bus.lft_spd !== 12'sd196) $display("FAIL roff_lat got=%0d want=196", bus.lft_spd); else passes++;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd0) $display("FAIL roff_lft got=%0d want=0", bus.lft_spd); else passes++;
        checks++; if (bus.rght_spd !== 12'sd0) $display("FAIL roff_rght got=%0d want=0", bus.rght_spd); else passes++;
        bus.rider_off = 1'b0; bus.en_steer = 1'b0;
        step(20);
        checks++; if (bus.ss_tmr !== 8'd20) $display("FAIL rst_ramp_ss got=%0d want=20", bus.ss_tmr); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ss_tmr !== 8'd0) $display("FAIL async_ss got=%0d want=0", bus.ss_tmr); else passes++;
        checks++; if (bus.lft_spd !== 12'sd0) $display("FAIL async_lft got=%0d want=0", bus.lft_spd); else passes++;
        rst_n = 1'b1;
        step(5);
        checks++; if (bus.ss_tmr !== 8'd5) $display("FAIL restart_ss got=%0d want=5", bus.ss_tmr); else passes++;
    endtask

`ifdef BAL_SLEW_LIMIT_EN
    task automatic test_slew;
        bus.pwr_up = 1'b1; bus.rider_off = 1'b0; bus.vld = 1'b1;
        bus.PID_cntrl = 12'sd0; bus.en_steer = 1'b0; bus.steer_pot = 12'h000;
        step(260);
        checks++; if (bus.ss_tmr !== 8'd255) $display("FAIL slew_ss got=%0d want=255", bus.ss_tmr); else passes++;
        bus.PID_cntrl = 12'sd1024;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd0) $display("FAIL slew_0 got=%0d want=0", bus.lft_spd); else passes++;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd64) $display("FAIL slew_1 got=%0d want=64", bus.lft_spd); else passes++;
        step(14);
        checks++; if (bus.lft_spd !== 12'sd960) $display("FAIL slew_15 got=%0d want=960", bus.lft_spd); else passes++;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd1024) $display("FAIL slew_16_lft got=%0d want=1024", bus.lft_spd); else passes++;
        checks++; if (bus.rght_spd !== 12'sd1024) $display("FAIL slew_16_rght got=%0d want=1024", bus.rght_spd); else passes++;
        bus.pwr_up = 1'b0;
        step(1);
        checks++; if (bus.lft_spd !== 12'sd0) $display("FAIL slew_pd got=%0d want=0", bus.lft_spd); else passes++;
    endtask
`endif

    initial begin
        test_reset;
`ifdef BAL_SLEW_LIMIT_EN
        test_slew;
`else
        test_soft_start;
        test_steering;
        test_overspeed;
        test_power_down;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/balance_spd_shaper.md
# balance_spd_shaper

Parametrised second-generation wheel-speed output stage for the segway balance path. It sits between the PID controller and the motor drive/PWM blocks, and takes the signed PID control word plus the steering pot. It owns the soft-start timer and blends in steering. Outputs are saturated, optionally slew-limited, and registered through a configurable-depth pipeline with a debounced overspeed flag.

## Interface
- SPD_W, 12: signed width of PID_cntrl and speed outputs; legal ≥12.
- PIPE_DEPTH, 2: register stages from input sample to output; legal 1..4.
- SS_W, 8: soft-start timer width.
- FAST_SIM, 1: 1 → ss_tmr steps on every vld; 0 → steps on every 16th vld.
- TOO_FAST_LIM, 1536: magnitude threshold on pre-saturation sums.
- TOO_FAST_CNT, 4: consecutive over-limit samples to assert too_fast; legal 1..15.
- SLEW_STEP, 64: max per-clock output change; used only with BAL_SLEW_LIMIT_EN.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- vld  in  1  new inertial sample strobe; advances soft-start.
- pwr_up  in  1  power enable; low forces zero output.
- rider_off  in  1  no rider; zeroes targets and soft-start.
- PID_cntrl  in  SPD_W  signed PID command.
- steer_pot  in  12  unsigned steering pot.
- en_steer  in  1  steering enable.
- lft_spd  out  SPD_W  signed left wheel speed.
- rght_spd  out  SPD_W  signed right wheel speed.
- too_fast  out  1  debounced overspeed flag.
- ss_tmr  out  SS_W  soft-start timer value (unsigned).

## Operation
- **Soft-start:**
  - ss_tmr clears synchronously when pwr_up=0 or rider_off=1.
  - Otherwise it increments by 1 on each qualifying vld and saturates at 2^SS_W−1.
  - With FAST_SIM=0, a 4-bit vld prescaler qualifies every 16th vld. The prescaler clears with ss_tmr.
- **Scaling:**
  - PID_ss = (PID_cntrl × {0,ss_tmr}) >>> SS_W, with a signed product of SPD_W+SS_W+1 bits.
  - When ss_tmr is at max, PID_ss = PID_cntrl exactly (no 255/256 loss).
- **Steering:**
  - steer_pot is clipped to [0x200, 0xE00], then 0x7FF is subtracted, giving a signed 12-bit value S.
  - steer = (S×3) >>> 4, sign-extended to SPD_W.
  - steer = 0 when en_steer=0 or rider_off=1.
- **Sums:**
  - lft_raw = PID_ss + steer and rght_raw = PID_ss − steer, each SPD_W+1 bits.
  - Each saturates to [−2^(SPD_W−1), 2^(SPD_W−1)−1].
  - rider_off=1 forces PID_ss = 0.
- **Overspeed:**
  - over = |lft_raw| > TOO_FAST_LIM or |rght_raw| > TOO_FAST_LIM.
  - A 4-bit counter increments per sampled cycle while over=1, saturating at TOO_FAST_CNT, and clears on any over=0 cycle.
  - too_fast = (count ≥ TOO_FAST_CNT). It is pipelined so it is aligned with the speeds computed from the same sample.
- **Power-down:** pwr_up=0 synchronously clears all pipeline registers, the counter and ss_tmr. Outputs are 0 after the next edge; this bypasses the slew limiter.
- **Reset:** lft_spd=0, rght_spd=0, too_fast=0, ss_tmr=0, all pipeline and counter state 0.

## Timing
- Inputs sampled at rising edge k (using ss_tmr as registered before k) appear on outputs after edge k+PIPE_DEPTH−1.
- With PIPE_DEPTH=1, the arithmetic is combinational into a single output register.
- too_fast has the same latency as the speeds: it asserts in the cycle the speeds from the TOO_FAST_CNT-th consecutive over sample appear.
- There is no backpressure; a new sample is taken every clock.
- vld and pwr_up falling in the same cycle: the clear wins, and ss_tmr=0 after the edge.
- rst_n assertion mid-ramp: immediate asynchronous clear. The ramp restarts from 0 after release.

## Configuration
- **BAL_SLEW_LIMIT_EN defined:** the final stage register updates each clock as out ← out + clamp(target − out, −SLEW_STEP, +SLEW_STEP), independently for left and right. too_fast is unaffected by slew.
- **Not defined:** the final stage loads the target directly, and SLEW_STEP is ignored.

## Test plan
All tests use the defaults unless noted: SPD_W=12, PIPE_DEPTH=2, SS_W=8, FAST_SIM=1, macro off.
1. Assert rst_n=0 with random inputs → lft_spd=rght_spd=0, too_fast=0, ss_tmr=0. Outputs hold 0 one cycle after release while pwr_up=0.
2. pwr_up=1, vld every cycle, PID_cntrl=1024, en_steer=0:
   - ss_tmr=128 → outputs 512.
   - ss_tmr saturates at 255 after 255 vlds → outputs 1024.
   - Output lags the sample edge by 1 cycle.
3. ss_tmr saturated, PID_cntrl=0, en_steer=1:
   - steer_pot=0xFFF → lft=288, rght=−288.
   - steer_pot=0x000 → lft=−288, rght=288.
   - en_steer=0 → both 0.
4. PID_cntrl=2000, steer_pot=0xE00, en_steer=1:
   - lft saturates to 2047, rght=1712.
   - too_fast rises with the 4th output cycle.
   - PID_cntrl=0 for one cycle → too_fast falls with that sample's output, and the count restarts.
5. Mid-ramp at ss_tmr=100, drop pwr_up → outputs 0 and ss_tmr 0 after the next edge. rider_off=1 alone → outputs 0 after pipeline latency, and ss_tmr 0.
6. With BAL_SLEW_LIMIT_EN, ss saturated, step PID_cntrl 0→1024 → outputs rise 64 per clock and reach 1024 after 16 clocks. Dropping pwr_up still gives 0 after the next edge.
